// File: rtl/instr_fetch_dispatch_pkg.sv
// Shared definitions for the instruction fetch/dispatch controller:
// opcodes, instruction field layout, state encoding and control bundle.
package instr_fetch_dispatch_pkg;

  // Opcode constants (instruction bits [15:12])
  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0011;
  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_HALT   = 4'b1111;
  localparam logic [3:0] OP_ILL_LO = 4'b1000;
  localparam logic [3:0] OP_ILL_HI = 4'b1110;

  // Instruction field positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int P1_MSB = 11;
  localparam int P1_LSB = 6;
  localparam int P2_MSB = 5;
  localparam int P2_LSB = 0;

  // Controller state encoding
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_READ  = 4'd2,
    S_F_LATCH = 4'd3,
    S_F_IR    = 4'd4,
    S_DECODE  = 4'd5,
    S_EXEC    = 4'd6,
    S_HALT    = 4'd7,
    S_FAULT   = 4'd8
  } state_e;

  // Per-cycle datapath control strobes
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic mar_en;
    logic mem_en;
    logic mem_rw;
    logic mdr_en_read;
    logic mdr_out;
    logic ir_en;
    logic exec_go;
  } ctrl_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
  endfunction

  // Reassemble the instruction word from its fields for the execution units
  function automatic logic [15:0] pack_instr(input logic [15:0] instr);
    return {instr[OP_MSB:OP_LSB], instr[P1_MSB:P1_LSB], instr[P2_MSB:P2_LSB]};
  endfunction

endpackage

// File: rtl/instr_fetch_dispatch_watchdog.sv
// EXEC-phase watchdog: counts cycles while enabled, flags the last allowed cycle.
module exec_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: restart on clear, advance while enabled, hold at the last value
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/instr_fetch_dispatch.sv
// Instruction fetch/decode/dispatch controller. Walks the memory path to load
// the IR, decodes the opcode, and hands the instruction to the execution units,
// guarding EXEC with a watchdog. All outputs come straight from flops.
module instr_fetch_dispatch
  import instr_fetch_dispatch_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] bus_in,
  input  logic        exec_done,
  output logic        PC_out,
  output logic        PC_inc,
  output logic        MAR_EN,
  output logic        mem_EN,
  output logic        mem_RW,
  output logic        MDR_EN_read,
  output logic        MDR_out,
  output logic        IR_EN,
  output logic [15:0] fullBitNum,
  output logic        exec_go,
  output logic        halted,
  output logic        illegal,
  output logic        timeout,
  output logic [7:0]  instr_count
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  count_q, count_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] full_q, full_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic        wd_expired_s;
  logic        in_exec_s;

  assign in_exec_s = (state_q == S_EXEC);

  exec_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_exec_s),
    .enable  (in_exec_s),
    .expired (wd_expired_s)
  );

  // Next-state, IR capture, retire counter and sticky status flags
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    count_d   = count_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_F_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_F_ADDR:  state_d = S_F_READ;
      S_F_READ:  state_d = S_F_LATCH;
      S_F_LATCH: state_d = S_F_IR;
      S_F_IR: begin
        ir_d    = bus_in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode_of(ir_q) == OP_NOP) begin
          count_d = count_q + 8'd1;
          state_d = run ? S_F_ADDR : S_IDLE;
        end else if (opcode_of(ir_q) == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (is_illegal(opcode_of(ir_q))) begin
          illegal_d = 1'b1;
          state_d   = S_FAULT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Completion takes priority over a same-cycle watchdog expiry
        if (exec_done) begin
          count_d = count_q + 8'd1;
          state_d = run ? S_F_ADDR : S_IDLE;
        end else if (wd_expired_s) begin
          timeout_d = 1'b1;
          state_d   = S_FAULT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      // Unreachable encodings park in the terminal fault state
      default: state_d = S_FAULT;
    endcase
  end

  // Control strobes for the state being entered, so they register alongside it
  always_comb begin
    ctrl_d = '0;
    full_d = 16'h0000;
    case (state_d)
      S_F_ADDR: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_en = 1'b1;
      end
      S_F_READ: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.mem_rw = 1'b1;
      end
      S_F_LATCH: begin
        ctrl_d.mem_en      = 1'b1;
        ctrl_d.mem_rw      = 1'b1;
        ctrl_d.mdr_en_read = 1'b1;
      end
      S_F_IR: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_en   = 1'b1;
      end
      S_DECODE: begin
        // DECODE is only entered from F_IR, so ir_d holds the new instruction
        ctrl_d.pc_inc = (opcode_of(ir_d) == OP_NOP);
      end
      S_EXEC: begin
        ctrl_d.exec_go = 1'b1;
        full_d         = pack_instr(ir_d);
      end
      default: begin
        ctrl_d = '0;
        full_d = 16'h0000;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ir_q      <= 16'h0000;
      count_q   <= 8'h00;
      ctrl_q    <= '0;
      full_q    <= 16'h0000;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      count_q   <= count_d;
      ctrl_q    <= ctrl_d;
      full_q    <= full_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign PC_out      = ctrl_q.pc_out;
  assign PC_inc      = ctrl_q.pc_inc;
  assign MAR_EN      = ctrl_q.mar_en;
  assign mem_EN      = ctrl_q.mem_en;
  assign mem_RW      = ctrl_q.mem_rw;
  assign MDR_EN_read = ctrl_q.mdr_en_read;
  assign MDR_out     = ctrl_q.mdr_out;
  assign IR_EN       = ctrl_q.ir_en;
  assign exec_go     = ctrl_q.exec_go;
  assign fullBitNum  = full_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Directed self-checking bench for instr_fetch_dispatch.
module tb_instr_fetch_dispatch;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] bus_in;
  logic        exec_done;
  logic        PC_out, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_out, IR_EN;
  logic [15:0] fullBitNum;
  logic        exec_go, halted, illegal, timeout;
  logic [7:0]  instr_count;
  logic [11:0] ctrl_s;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_dispatch #(.TIMEOUT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .bus_in      (bus_in),
    .exec_done   (exec_done),
    .PC_out      (PC_out),
    .PC_inc      (PC_inc),
    .MAR_EN      (MAR_EN),
    .mem_EN      (mem_EN),
    .mem_RW      (mem_RW),
    .MDR_EN_read (MDR_EN_read),
    .MDR_out     (MDR_out),
    .IR_EN       (IR_EN),
    .fullBitNum  (fullBitNum),
    .exec_go     (exec_go),
    .halted      (halted),
    .illegal     (illegal),
    .timeout     (timeout),
    .instr_count (instr_count)
  );

  // {PC_out, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_out, IR_EN,
  //  exec_go, halted, illegal, timeout}
  assign ctrl_s = {PC_out, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_out, IR_EN,
                   exec_go, halted, illegal, timeout};

  localparam logic [11:0] C_IDLE  = 12'h000;
  localparam logic [11:0] C_EXEC  = 12'h008;
  localparam logic [11:0] C_NOP   = 12'h400;
  localparam logic [11:0] C_HALT  = 12'h004;
  localparam logic [11:0] C_ILL   = 12'h002;
  localparam logic [11:0] C_TMO   = 12'h001;
  localparam logic [11:0] C_FADDR = 12'hA00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL tb_time_limit: bench still running at %0t, required to finish", $time);
    $fatal(1);
  end

  // Expected strobes for fetch cycle c (1 = F_ADDR .. 4 = F_IR)
  function automatic logic [11:0] exp_fetch(input int c);
    case (c)
      1:       return 12'hA00;
      2:       return 12'h180;
      3:       return 12'h1C0;
      4:       return 12'h030;
      default: return 12'h000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    exec_done = 1'b0;
    bus_in = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run = 1'b1;
    exec_done = 1'b0;
    bus_in = 16'h4083;
    #2;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL reset_ctrl: got %h want %h", ctrl_s, C_IDLE); end
    n_cmp++;
    if (fullBitNum !== 16'h0000) begin n_bad++; $display("FAIL reset_full: got %h want 0000", fullBitNum); end
    n_cmp++;
    if (instr_count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", instr_count); end
    step();
    step();
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL reset_hold: got %h want %h", ctrl_s, C_IDLE); end
  endtask

  task automatic test_load();
    logic [11:0] exp_c;
    logic [15:0] exp_f;
    do_reset();
    run = 1'b1;
    bus_in = 16'h4083;
    for (int c = 1; c <= 10; c++) begin
      step();
      exec_done = 1'b0;
      exp_c = (c <= 5) ? exp_fetch(c) : C_EXEC;
      exp_f = (c >= 6) ? 16'h4083 : 16'h0000;
      n_cmp++;
      if (ctrl_s !== exp_c) begin n_bad++; $display("FAIL load_ctrl_c%0d: got %h want %h", c, ctrl_s, exp_c); end
      n_cmp++;
      if (fullBitNum !== exp_f) begin n_bad++; $display("FAIL load_full_c%0d: got %h want %h", c, fullBitNum, exp_f); end
      n_cmp++;
      if (instr_count !== 8'h00) begin n_bad++; $display("FAIL load_count_c%0d: got %h want 00", c, instr_count); end
      // A stray completion pulse during fetch must be ignored
      if (c == 2) exec_done = 1'b1;
      if (c == 10) exec_done = 1'b1;
    end
    step();
    exec_done = 1'b0;
    n_cmp++;
    if (ctrl_s !== C_FADDR) begin n_bad++; $display("FAIL load_next: got %h want %h", ctrl_s, C_FADDR); end
    n_cmp++;
    if (instr_count !== 8'h01) begin n_bad++; $display("FAIL load_retire: got %h want 01", instr_count); end
    n_cmp++;
    if (fullBitNum !== 16'h0000) begin n_bad++; $display("FAIL load_full_after: got %h want 0000", fullBitNum); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_c;
    logic [15:0] exp_f;
    do_reset();
    run = 1'b1;
    bus_in = 16'h3080;
    for (int c = 1; c <= 12; c++) begin
      step();
      exec_done = 1'b0;
      if (c <= 5)       exp_c = exp_fetch(c);
      else if (c == 6)  exp_c = C_EXEC;
      else if (c <= 11) exp_c = exp_fetch(c - 6);
      else              exp_c = C_EXEC;
      exp_f = (c == 6 || c == 12) ? 16'h3080 : 16'h0000;
      n_cmp++;
      if (ctrl_s !== exp_c) begin n_bad++; $display("FAIL b2b_ctrl_c%0d: got %h want %h", c, ctrl_s, exp_c); end
      n_cmp++;
      if (fullBitNum !== exp_f) begin n_bad++; $display("FAIL b2b_full_c%0d: got %h want %h", c, fullBitNum, exp_f); end
      if (c == 6) exec_done = 1'b1;
    end
    exec_done = 1'b1;
    run = 1'b0;
    step();
    exec_done = 1'b0;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL b2b_idle: got %h want %h", ctrl_s, C_IDLE); end
    n_cmp++;
    if (instr_count !== 8'h02) begin n_bad++; $display("FAIL b2b_count: got %h want 02", instr_count); end
  endtask

  task automatic test_nop();
    int pc_cnt = 0;
    int go_cnt = 0;
    do_reset();
    run = 1'b1;
    bus_in = 16'h0000;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 5) begin
        n_cmp++;
        if (ctrl_s !== C_NOP) begin n_bad++; $display("FAIL nop_decode: got %h want %h", ctrl_s, C_NOP); end
      end
      pc_cnt += int'(PC_inc);
      go_cnt += int'(exec_go);
      if (c == 4) run = 1'b0;
    end
    n_cmp++;
    if (pc_cnt != 1) begin n_bad++; $display("FAIL nop_pcinc_pulses: got %0d want 1", pc_cnt); end
    n_cmp++;
    if (go_cnt != 0) begin n_bad++; $display("FAIL nop_exec_go: got %0d want 0", go_cnt); end
    n_cmp++;
    if (instr_count !== 8'h01) begin n_bad++; $display("FAIL nop_count: got %h want 01", instr_count); end
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL nop_idle: got %h want %h", ctrl_s, C_IDLE); end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    run = 1'b1;
    bus_in = 16'h9000;
    repeat (6) step();
    n_cmp++;
    if (ctrl_s !== C_ILL) begin n_bad++; $display("FAIL illegal_flag: got %h want %h", ctrl_s, C_ILL); end
    exec_done = 1'b1;
    repeat (4) step();
    exec_done = 1'b0;
    n_cmp++;
    if (ctrl_s !== C_ILL) begin n_bad++; $display("FAIL illegal_held: got %h want %h", ctrl_s, C_ILL); end
    n_cmp++;
    if (instr_count !== 8'h00) begin n_bad++; $display("FAIL illegal_count: got %h want 00", instr_count); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL illegal_clear: got %h want %h", ctrl_s, C_IDLE); end

    do_reset();
    run = 1'b1;
    bus_in = 16'hF000;
    repeat (6) step();
    n_cmp++;
    if (ctrl_s !== C_HALT) begin n_bad++; $display("FAIL halt_flag: got %h want %h", ctrl_s, C_HALT); end
    repeat (4) step();
    n_cmp++;
    if (ctrl_s !== C_HALT) begin n_bad++; $display("FAIL halt_held: got %h want %h", ctrl_s, C_HALT); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL halt_clear: got %h want %h", ctrl_s, C_IDLE); end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    bus_in = 16'h4083;
    repeat (6) step();
    run = 1'b0;
    repeat (31) step();
    n_cmp++;
    if (ctrl_s !== C_EXEC) begin n_bad++; $display("FAIL tmo_last_exec: got %h want %h", ctrl_s, C_EXEC); end
    step();
    n_cmp++;
    if (ctrl_s !== C_TMO) begin n_bad++; $display("FAIL tmo_fault: got %h want %h", ctrl_s, C_TMO); end
    n_cmp++;
    if (fullBitNum !== 16'h0000) begin n_bad++; $display("FAIL tmo_full: got %h want 0000", fullBitNum); end

    do_reset();
    run = 1'b1;
    bus_in = 16'h4083;
    repeat (6) step();
    run = 1'b0;
    repeat (31) step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL tmo_done_wins: got %h want %h", ctrl_s, C_IDLE); end
    n_cmp++;
    if (instr_count !== 8'h01) begin n_bad++; $display("FAIL tmo_done_count: got %h want 01", instr_count); end
    repeat (3) step();
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL tmo_no_late_fault: got %h want %h", ctrl_s, C_IDLE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    bus_in = 16'h4083;
    repeat (7) step();
    n_cmp++;
    if (ctrl_s !== C_EXEC) begin n_bad++; $display("FAIL rmid_exec: got %h want %h", ctrl_s, C_EXEC); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL rmid_exec_ctrl: got %h want %h", ctrl_s, C_IDLE); end
    n_cmp++;
    if (fullBitNum !== 16'h0000) begin n_bad++; $display("FAIL rmid_exec_full: got %h want 0000", fullBitNum); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    n_cmp++;
    if (ctrl_s !== C_FADDR) begin n_bad++; $display("FAIL rmid_restart1: got %h want %h", ctrl_s, C_FADDR); end

    do_reset();
    run = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (ctrl_s !== 12'h180) begin n_bad++; $display("FAIL rmid_fread: got %h want 180", ctrl_s); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_s !== C_IDLE) begin n_bad++; $display("FAIL rmid_fread_ctrl: got %h want %h", ctrl_s, C_IDLE); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    n_cmp++;
    if (ctrl_s !== C_FADDR) begin n_bad++; $display("FAIL rmid_restart2: got %h want %h", ctrl_s, C_FADDR); end
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    exec_done = 1'b0;
    bus_in = 16'h0000;
    test_reset();
    test_load();
    test_back_to_back();
    test_nop();
    test_illegal_halt();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
